ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 o_mem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 o_mem_addr  output  32  SHALL be the word-aligned read address, bits [1:0] always 0.
REQ-006 i_mem_ack  input  1  SHALL complete a read when high at a rising edge while o_mem_req is high.
REQ-007 i_mem_rdata  input  32  SHALL be the read word, valid in the ack cycle.
REQ-008 o_valid  output  1  SHALL flag that o_instr/o_pc hold a fetched instruction for the decode stage.
REQ-009 o_instr  output  32  SHALL be the fetched instruction word, condition field in [31:28].
REQ-010 o_pc  output  32  SHALL be the address o_instr was fetched from.
REQ-011 i_ready  input  1  SHALL signal that decode accepts o_instr at this rising edge.
REQ-012 i_redirect  input  1  SHALL request a fetch redirect (branch/BL taken, SWI, exception).
REQ-013 i_redirect_pc  input  32  SHALL be the redirect target; bits [1:0] SHALL be ignored and treated as 0.

Function
REQ-014 The block SHALL implement states REQ (read outstanding) and HOLD (instruction buffered) plus a squash flag.
REQ-015 In REQ, o_mem_req SHALL be 1 and o_mem_addr SHALL hold the fetch PC, both stable until ack.
REQ-016 In HOLD, o_mem_req SHALL be 0.
REQ-017 REQ with ack and squash=0: capture rdata into o_instr, fetch PC into o_pc, set o_valid=1 in the next cycle, go to HOLD.
REQ-018 HOLD with i_ready=1 and no redirect: clear o_valid, set fetch PC to o_pc+4, go to REQ; the new request SHALL appear the cycle after acceptance.
REQ-019 HOLD with i_ready=0: o_valid, o_instr and o_pc SHALL hold unchanged.
REQ-020 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-021 Redirect in HOLD: drop the buffered instruction (o_valid=0 next cycle), fetch PC = redirect target, go to REQ; redirect SHALL take priority over a simultaneous i_ready.
REQ-022 Redirect in REQ without ack in that cycle: keep o_mem_req and the old address stable, set squash, latch the target.
REQ-023 Ack with squash=1: discard rdata, keep o_valid=0, clear squash, issue the request to the latched target next cycle.
REQ-024 Redirect and ack in the same REQ cycle: discard rdata, fetch PC = new target, stay in REQ with a new request next cycle.
REQ-025 A later redirect while squash is set SHALL overwrite the latched target (last redirect wins).
REQ-026 i_mem_ack while o_mem_req=0 SHALL be ignored.
REQ-027 Peak throughput SHALL be one instruction per 2 cycles with zero-wait-state memory (ack in the request cycle).

Reset
REQ-028 While rst_n=0: o_mem_req=0, o_valid=0, o_instr=0, o_pc=0, squash=0, fetch PC=RESET_PC, state=REQ; this SHALL take effect immediately, regardless of clk.
REQ-029 First rising edge after rst_n deasserts: o_mem_req=1 and o_mem_addr=RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding read; any ack for it SHALL not produce o_valid.

Verification
REQ-031 Reset release with RESET_PC=0, memory acks in the request cycle, i_ready=1 -> o_pc sequence 0,4,8,12 with o_valid high every second cycle.
REQ-032 i_ready=0 for 5 cycles while o_valid=1 -> o_instr/o_pc stable, o_mem_req=0 throughout; one fetch resumes after i_ready=1.
REQ-033 Redirect to 32'h0000_0102 in the same cycle as i_ready=1 in HOLD -> buffered word dropped, next o_mem_addr=32'h0000_0100.
REQ-034 Redirect to 32'h200 while a read to 32'h40 waits 3 cycles for ack -> address stays 32'h40 until ack, data discarded, next request 32'h200, o_valid stays 0.
REQ-035 Fetch PC 32'hFFFF_FFFC accepted -> next o_mem_addr=32'h0000_0000.
REQ-036 rst_n pulsed low mid-wait, then stale ack -> o_valid=0, first request after release to RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: single-outstanding-read instruction fetch stage.
//
// Reads one word at a time from instruction memory and buffers it for the
// decode stage. A redirect either restarts fetch immediately (no read in
// flight) or marks the in-flight read to be squashed, since the memory
// request must stay stable until it is acknowledged.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   o_mem_req           instruction-memory read request
//   o_mem_addr[31:0]    word-aligned read address
//   i_mem_ack           read completes when high with o_mem_req
//   i_mem_rdata[31:0]   read word, valid in the ack cycle
//   o_valid             o_instr/o_pc hold a fetched instruction
//   o_instr[31:0]       fetched instruction word
//   o_pc[31:0]          address o_instr was fetched from
//   i_ready             decode accepts o_instr at this edge
//   i_redirect          redirect fetch to i_redirect_pc
//   i_redirect_pc[31:0] redirect target (bits [1:0] ignored)
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  typedef enum logic {
    ST_REQ,
    ST_HOLD
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  state_t      state_q, state_d;
  logic        started_q;
  logic        squash_q, squash_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] redir_tgt;

  assign redir_tgt  = i_redirect_pc & ~32'd3;

  // The first cycle after reset release issues no request; started_q gates
  // the request so it appears on the first edge after release.
  assign o_mem_req  = started_q && (state_q == ST_REQ);
  assign o_mem_addr = pc_q;
  assign o_valid    = valid_q;
  assign o_instr    = instr_q;
  assign o_pc       = opc_q;

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    unique case (state_q)
      ST_REQ: begin
        if (!started_q) begin
          // No read issued yet, so a redirect can retarget directly.
          if (i_redirect) pc_d = redir_tgt;
        end else if (i_mem_ack) begin
          squash_d = 1'b0;
          if (i_redirect) begin
            pc_d = redir_tgt;
          end else if (squash_q) begin
            pc_d = tgt_q;
          end else begin
            valid_d = 1'b1;
            instr_d = i_mem_rdata;
            opc_d   = pc_q;
            state_d = ST_HOLD;
          end
        end else if (i_redirect) begin
          // Read in flight: keep address stable, remember where to go.
          squash_d = 1'b1;
          tgt_d    = redir_tgt;
        end
      end
      ST_HOLD: begin
        if (i_redirect) begin
          valid_d = 1'b0;
          pc_d    = redir_tgt;
          state_d = ST_REQ;
        end else if (i_ready) begin
          valid_d = 1'b0;
          pc_d    = opc_q + 32'd4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      started_q <= 1'b0;
      squash_q  <= 1'b0;
      pc_q      <= RESET_PC_ALIGNED;
      tgt_q     <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      opc_q     <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      squash_q  <= squash_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a transaction-level model.
module tb_ifetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;

  logic mem_auto = 1'b1;
  logic ack_force = 1'b0;

  int errors = 0;
  int checks = 0;

  ifetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .i_ready(i_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: zero-wait ack when mem_auto, or a forced ack from the stimulus.
  always_comb begin
    i_mem_ack   = (mem_auto && o_mem_req) || ack_force;
    i_mem_rdata = mem_word(o_mem_addr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one outstanding read (or a buffered instruction), a pending
  // "drop the read in flight" flag with its retarget address.
  logic        m_started = 1'b0;
  logic        m_have = 1'b0;
  logic [31:0] m_addr = TB_RESET_PC & ~32'd3;
  logic        m_drop = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] rt;
    rt = i_redirect_pc & ~32'd3;
    if (!rst_n) begin
      m_started = 1'b0; m_have = 1'b0; m_drop = 1'b0;
      m_addr = TB_RESET_PC & ~32'd3; m_instr = '0; m_pc = '0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (i_redirect) m_addr = rt;
    end else if (!m_have) begin
      if (i_mem_ack) begin
        if (i_redirect) begin
          m_addr = rt; m_drop = 1'b0;
        end else if (m_drop) begin
          m_addr = m_tgt; m_drop = 1'b0;
        end else begin
          m_have = 1'b1; m_instr = mem_word(m_addr); m_pc = m_addr;
        end
      end else if (i_redirect) begin
        m_drop = 1'b1; m_tgt = rt;
      end
    end else if (i_redirect) begin
      m_have = 1'b0; m_addr = rt;
    end else if (i_ready) begin
      m_have = 1'b0; m_addr = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    check("mdl_req", {31'd0, o_mem_req}, {31'd0, m_started && !m_have});
    check("mdl_valid", {31'd0, o_valid}, {31'd0, m_have});
    if (m_started && !m_have) check("mdl_addr", o_mem_addr, m_addr);
    if (m_have) begin
      check("mdl_pc", o_pc, m_pc);
      check("mdl_instr", o_instr, m_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcount;
    int vidx[$];
    logic [31:0] vpc[$];
    int reqs;

    // Reset state, immediately and across edges.
    #1;
    check("rst_req", {31'd0, o_mem_req}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    tick(); tick();
    check("rst_req2", {31'd0, o_mem_req}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_req", {31'd0, o_mem_req}, 32'd1);
    check("first_addr", o_mem_addr, 32'h0000_0000);

    // Zero-wait streaming: pc 0,4,8,12 with valid every second cycle.
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_valid) begin
        vidx.push_back(i);
        vpc.push_back(o_pc);
      end
    end
    check("stream_count", vidx.size(), 32'd4);
    if (vidx.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("stream_pc", vpc[k], 32'(4 * k));
        check("stream_cycle", vidx[k], 32'(2 * k));
      end
    end

    // Decode stall for 5 cycles with pc 16 buffered.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, o_valid}, 32'd1);
      check("stall_pc", o_pc, 32'h10);
      check("stall_instr", o_instr, mem_word(32'h10));
      check("stall_req", {31'd0, o_mem_req}, 32'd0);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    reqs = 0;
    if (o_mem_req) reqs++;
    check("resume_addr", o_mem_addr, 32'h14);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_mem_req) reqs++;
    end
    check("resume_reqs", reqs, 32'd1);
    check("resume_pc", o_pc, 32'h14);

    // Redirect beats simultaneous accept in HOLD.
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0102; i_ready = 1'b1;
    tick();
    i_redirect = 1'b0; i_ready = 1'b0;
    check("hold_redir_valid", {31'd0, o_valid}, 32'd0);
    check("hold_redir_addr", o_mem_addr, 32'h0000_0100);
    tick();
    check("hold_redir_pc", o_pc, 32'h0000_0100);

    // Redirects while a read to 0x40 waits; last one (0x200) wins.
    mem_auto = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick();
    i_redirect_pc = 32'h180;
    tick();
    check("wait_addr1", o_mem_addr, 32'h40);
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 1'b0;
    check("wait_addr2", o_mem_addr, 32'h40);
    tick();
    check("wait_addr3", o_mem_addr, 32'h40);
    check("wait_req", {31'd0, o_mem_req}, 32'd1);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0; mem_auto = 1'b1;
    check("squash_valid", {31'd0, o_valid}, 32'd0);
    check("squash_addr", o_mem_addr, 32'h200);
    tick();
    check("squash_pc", o_pc, 32'h200);

    // Redirect and ack in the same request cycle.
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    tick();
    i_redirect = 1'b0;
    check("ackredir_valid", {31'd0, o_valid}, 32'd0);
    check("ackredir_addr", o_mem_addr, 32'h300);
    tick();
    check("ackredir_pc", o_pc, 32'h300);

    // Wrap: 0xFFFF_FFFC + 4 -> 0.
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
    tick();
    i_redirect = 1'b0;
    check("wrap_addr0", o_mem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("wrap_addr", o_mem_addr, 32'h0000_0000);
    tick();

    // Ack with no request outstanding changes nothing.
    ack_force = 1'b1;
    tick(); tick();
    ack_force = 1'b0;
    check("stray_ack_valid", {31'd0, o_valid}, 32'd1);
    check("stray_ack_pc", o_pc, 32'h0);

    // Reset mid-wait, stale ack afterwards.
    mem_auto = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 32'h80;
    tick();
    i_redirect = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, o_mem_req}, 32'd0);
    check("async_rst_valid", {31'd0, o_valid}, 32'd0);
    tick();
    ack_force = 1'b1;
    rst_n = 1'b1;
    tick();
    check("post_rst_req", {31'd0, o_mem_req}, 32'd1);
    check("post_rst_addr", o_mem_addr, TB_RESET_PC);
    check("post_rst_valid", {31'd0, o_valid}, 32'd0);
    ack_force = 1'b0;
    tick();
    check("stale_valid", {31'd0, o_valid}, 32'd0);
    mem_auto = 1'b1; i_ready = 1'b1;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
